// File: rtl/csr_unit_pkg.sv
// Shared CSR-unit definitions: bus widths, CSR numbers, field positions, exception codes.
// Timer CSRs (TCFG/TVAL/TICLR) exist only when CSR_TIMER_EN is defined.
package csr_unit_pkg;

    localparam int WB2CSR_LEN   = 81;
    localparam int CSR_CTRL_LEN = 80;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int CRMD_IE       = 2;
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TICLR_CLR     = 0;

    // LIE bit 10 does not exist in the architecture.
    localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF;
    localparam logic [3:0]  CRMD_RESET    = 4'h8;

    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;

    typedef struct packed {
        logic        re;
        logic [13:0] num;
        logic        we;
        logic [31:0] wmask;
        logic [31:0] wvalue;
    } csr_ctrl_t;

    typedef struct packed {
        logic        ertn_flush;
        logic        wb_ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } wb2csr_t;

    typedef enum logic {
        TMR_IDLE  = 1'b0,
        TMR_COUNT = 1'b1
    } timer_state_t;

    function automatic logic [31:0] mask_write(input logic [31:0] old_val,
                                               input logic [31:0] wmask,
                                               input logic [31:0] wvalue);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: owns TVAL and the IDLE/COUNT sequencing, pulses timer_fire on the 1->0 step.
// Latency: TCFG write loads TVAL on the next edge; timer_fire is combinational from state.
// Backpressure: none, always accepts.
module csr_timer
    import csr_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tcfg_we,
    input  logic        new_en,
    input  logic [29:0] new_init,
    input  logic        periodic,
    input  logic [29:0] init_val,
    output logic [31:0] tval,
    output logic        timer_fire
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic [31:0]  tval_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TMR_IDLE;
            tval    <= '0;
        end else begin
            state_q <= state_d;
            tval    <= tval_d;
        end
    end

    // A TCFG write overrides the count step of the same cycle.
    always_comb begin
        state_d = state_q;
        tval_d  = tval;
        if (tcfg_we) begin
            if (new_en) begin
                tval_d  = {new_init, 2'b00};
                state_d = (new_init != '0) ? TMR_COUNT : TMR_IDLE;
            end else begin
                state_d = TMR_IDLE;
            end
        end else if (state_q == TMR_COUNT) begin
            if (tval == 32'd1) begin
                if (periodic) begin
                    tval_d = {init_val, 2'b00};
                end else begin
                    tval_d  = '0;
                    state_d = TMR_IDLE;
                end
            end else begin
                tval_d = tval - 32'd1;
            end
        end
    end

    always_comb begin
        timer_fire = (state_q == TMR_COUNT) && (tval == 32'd1) && !tcfg_we;
    end

endmodule

// File: rtl/csr_unit.sv
// CSR file: masked writes, exception/ertn commit, interrupt sampling; timer gated by CSR_TIMER_EN.
// Latency: reads combinational, all updates visible the cycle after the event.
// Backpressure: none, every cycle is accepted.
module csr_unit
    import csr_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CSR_CTRL_LEN-1:0] csr_ctrl,
    input  logic [WB2CSR_LEN-1:0]   to_csr_in_bus,
    input  logic [7:0]              hw_int_in,
    input  logic                    ipi_int_in,
    output logic [31:0]             csr_rvalue,
    output logic [31:0]             ex_entry,
    output logic [31:0]             ertn_entry,
    output logic                    has_int
);

    csr_ctrl_t ctl;
    wb2csr_t   wb;
    assign ctl = csr_ctrl;
    assign wb  = to_csr_in_bus;

    logic [3:0]  crmd;
    logic [2:0]  prmd;
    logic [12:0] ecfg_lie;
    logic [1:0]  is_sw;
    logic [7:0]  is_hw;
    logic        is_ipi;
    logic        is_ti;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] era;
    logic [31:0] badv;
    logic [25:0] eentry_va;
    logic [31:0] save0, save1, save2, save3;
    logic [31:0] tid;

    logic [12:0] estat_is;
    logic        sw_we;
    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic        unused_ok;

    assign estat_is  = {is_ipi, is_ti, 1'b0, is_hw, is_sw};
    // Exception and ertn discard any CSR write presented in the same cycle.
    assign sw_we     = ctl.we && !wb.wb_ex && !wb.ertn_flush;
    assign unused_ok = ctl.re;

`ifdef CSR_TIMER_EN
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic        timer_fire;
    logic        tcfg_we;
    logic        ticlr_we;
`endif

    always_comb begin
        rd_val = '0;
        case (ctl.num)
            CSR_CRMD:   rd_val = {28'b0, crmd};
            CSR_PRMD:   rd_val = {29'b0, prmd};
            CSR_ECFG:   rd_val = {19'b0, ecfg_lie};
            CSR_ESTAT:  rd_val = {1'b0, esubcode, ecode, 3'b0, estat_is};
            CSR_ERA:    rd_val = era;
            CSR_BADV:   rd_val = badv;
            CSR_EENTRY: rd_val = {eentry_va, 6'b0};
            CSR_SAVE0:  rd_val = save0;
            CSR_SAVE1:  rd_val = save1;
            CSR_SAVE2:  rd_val = save2;
            CSR_SAVE3:  rd_val = save3;
            CSR_TID:    rd_val = tid;
`ifdef CSR_TIMER_EN
            CSR_TCFG:   rd_val = tcfg;
            CSR_TVAL:   rd_val = tval;
`endif
            default:    rd_val = '0;
        endcase
    end

    assign csr_rvalue = rd_val;
    // Merging against the read value keeps reserved bits at zero.
    assign wr_val     = mask_write(rd_val, ctl.wmask, ctl.wvalue);

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd      <= CRMD_RESET;
            prmd      <= '0;
            ecfg_lie  <= '0;
            is_sw     <= '0;
            is_hw     <= '0;
            is_ipi    <= 1'b0;
            ecode     <= '0;
            esubcode  <= '0;
            era       <= '0;
            badv      <= '0;
            eentry_va <= '0;
            save0     <= '0;
            save1     <= '0;
            save2     <= '0;
            save3     <= '0;
            tid       <= '0;
        end else begin
            is_hw  <= hw_int_in;
            is_ipi <= ipi_int_in;
            if (wb.wb_ex) begin
                prmd     <= crmd[2:0];
                crmd     <= {crmd[3], 3'b000};
                ecode    <= wb.ecode;
                esubcode <= wb.esubcode;
                era      <= wb.pc;
                if (wb.ecode == ECODE_ADE || wb.ecode == ECODE_ALE) begin
                    badv <= wb.vaddr;
                end
            end else if (wb.ertn_flush) begin
                crmd <= {crmd[3], prmd};
            end else if (sw_we) begin
                case (ctl.num)
                    CSR_CRMD:   crmd      <= wr_val[3:0];
                    CSR_PRMD:   prmd      <= wr_val[2:0];
                    CSR_ECFG:   ecfg_lie  <= wr_val[12:0] & ECFG_LIE_MASK;
                    CSR_ESTAT:  is_sw     <= wr_val[1:0];
                    CSR_ERA:    era       <= wr_val;
                    CSR_BADV:   badv      <= wr_val;
                    CSR_EENTRY: eentry_va <= wr_val[31:6];
                    CSR_SAVE0:  save0     <= wr_val;
                    CSR_SAVE1:  save1     <= wr_val;
                    CSR_SAVE2:  save2     <= wr_val;
                    CSR_SAVE3:  save3     <= wr_val;
                    CSR_TID:    tid       <= wr_val;
                    default:    ;
                endcase
            end
        end
    end

`ifdef CSR_TIMER_EN
    assign tcfg_we  = sw_we && (ctl.num == CSR_TCFG);
    assign ticlr_we = sw_we && (ctl.num == CSR_TICLR);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg  <= '0;
            is_ti <= 1'b0;
        end else begin
            if (tcfg_we) begin
                tcfg <= wr_val;
            end
            // A fire landing with a TICLR clear leaves the flag set.
            if (timer_fire) begin
                is_ti <= 1'b1;
            end else if (ticlr_we && ctl.wvalue[TICLR_CLR] && ctl.wmask[TICLR_CLR]) begin
                is_ti <= 1'b0;
            end
        end
    end

    csr_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .tcfg_we    (tcfg_we),
        .new_en     (wr_val[TCFG_EN]),
        .new_init   (wr_val[31:2]),
        .periodic   (tcfg[TCFG_PERIODIC]),
        .init_val   (tcfg[31:2]),
        .tval       (tval),
        .timer_fire (timer_fire)
    );
`else
    assign is_ti = 1'b0;
`endif

    assign has_int    = crmd[CRMD_IE] & (|(estat_is & ecfg_lie));
    assign ex_entry   = {eentry_va, 6'b0};
    assign ertn_entry = era;

endmodule

// File: tb/tb_csr_unit.sv
// Directed plus random bench for csr_unit against a register-level behavioural model.
module tb_csr_unit;

`ifdef CSR_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        re, we, ex, ertn, ipi;
    logic [13:0] num;
    logic [31:0] wmask, wvalue, pc, vaddr;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [7:0]  hw;
    logic [31:0] csr_rvalue, ex_entry, ertn_entry;
    logic        has_int;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csr_unit dut (
        .clk           (clk),
        .reset         (reset),
        .csr_ctrl      ({re, num, we, wmask, wvalue}),
        .to_csr_in_bus ({ertn, ex, ecode, esub, pc, vaddr}),
        .hw_int_in     (hw),
        .ipi_int_in    (ipi),
        .csr_rvalue    (csr_rvalue),
        .ex_entry      (ex_entry),
        .ertn_entry    (ertn_entry),
        .has_int       (has_int)
    );

    // Model: one word per CSR number as software would read it, plus the timer count.
    logic [31:0] mr [0:127];
    logic [31:0] m_tval;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask_of(input logic [13:0] n);
        case (n)
            14'h00: return 32'h0000_000F;
            14'h01: return 32'h0000_0007;
            14'h04: return 32'h0000_1BFF;
            14'h05: return 32'h0000_0003;
            14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40: return 32'hFFFF_FFFF;
            14'h0C: return 32'hFFFF_FFC0;
            14'h41: return TMR ? 32'hFFFF_FFFF : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] n);
        if (n == 14'h42) return TMR ? m_tval : 32'h0;
        if (wmask_of(n) != 32'h0) return mr[n[6:0]];
        return 32'h0;
    endfunction

    function automatic logic m_has_int();
        return mr[0][2] && ((mr[5] & mr[4] & 32'h1FFF) != 32'h0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mr[i] = 32'h0;
        mr[0]  = 32'h8;
        m_tval = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] tcfg_old, nv, wm;
        logic        fire, clr, sw;
        if (reset) begin
            model_reset();
            return;
        end
        fire     = 1'b0;
        clr      = 1'b0;
        sw       = we && !ex && !ertn;
        wm       = wmask & wmask_of(num);
        nv       = (m_read(num) & ~wm) | (wvalue & wm);
        tcfg_old = mr[7'h41];
        if (TMR) begin
            if (sw && num == 14'h41) begin
                if (nv[0]) m_tval = {nv[31:2], 2'b00};
            end else if (tcfg_old[0] && m_tval != 32'h0) begin
                if (m_tval == 32'h1) begin
                    fire   = 1'b1;
                    m_tval = tcfg_old[1] ? {tcfg_old[31:2], 2'b00} : 32'h0;
                end else begin
                    m_tval = m_tval - 32'h1;
                end
            end
        end
        if (ex) begin
            mr[1] = mr[0] & 32'h7;
            mr[0] = mr[0] & 32'h8;
            mr[5] = (mr[5] & 32'h1FFF) | ({23'b0, esub} << 22) | ({26'b0, ecode} << 16);
            mr[6] = pc;
            if (ecode == 6'h8 || ecode == 6'h9) mr[7] = vaddr;
        end else if (ertn) begin
            mr[0] = (mr[0] & 32'h8) | (mr[1] & 32'h7);
        end else if (we) begin
            if (TMR && num == 14'h44) clr = wvalue[0] & wmask[0];
            else if (wmask_of(num) != 32'h0) mr[num[6:0]] = nv;
        end
        mr[5][9:2] = hw;
        mr[5][12]  = ipi;
        if (fire) mr[5][11] = 1'b1;
        else if (clr) mr[5][11] = 1'b0;
    endtask

    // Check outputs against the model, then advance one clock.
    task automatic cyc();
        #1;
        chk("rvalue", csr_rvalue, m_read(num));
        chk("ex_entry", ex_entry, mr[7'h0C]);
        chk("ertn_entry", ertn_entry, mr[7'h06]);
        chk("has_int", {31'b0, has_int}, {31'b0, m_has_int()});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        re = 1'b1; we = 1'b0; ex = 1'b0; ertn = 1'b0;
        wmask = 32'h0; wvalue = 32'h0; ecode = 6'h0; esub = 9'h0;
        pc = 32'h0; vaddr = 32'h0;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
        idle_in();
        num = n; we = 1'b1; wvalue = v; wmask = m;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] n, output logic [31:0] v);
        num = n;
        #1;
        v = csr_rvalue;
    endtask

    logic [31:0] v, r;
    int          cnt;
    logic [13:0] nums [18] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30,
                               14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02,
                               14'h100, 14'h3FFF};
    logic [5:0]  ecodes [4] = '{6'h08, 6'h09, 6'h0B, 6'h00};

    initial begin
        idle_in();
        num = 14'h0; hw = 8'h0; ipi = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;

        // Reset state
        rd(14'h00, v); chk("reset_crmd", v, 32'h8);
        rd(14'h05, v); chk("reset_estat", v, 32'h0);
        chk("reset_has_int", {31'b0, has_int}, 32'h0);

        // Masked EENTRY writes
        wr(14'h0C, 32'h1C00_8000, 32'hFFFF_FFFF);
        chk("eentry_full", ex_entry, 32'h1C00_8000);
        wr(14'h0C, 32'hFFFF_FFFF, 32'h0000_003F);
        chk("eentry_masked", ex_entry, 32'h1C00_8000);

        // Exception commit then ertn
        wr(14'h00, 32'hF, 32'hF);
        idle_in(); ex = 1'b1; ecode = 6'h0B; pc = 32'h1C00_0100; num = 14'h00;
        cyc(); idle_in();
        rd(14'h00, v); chk("ex_crmd", v, 32'h8);
        rd(14'h01, v); chk("ex_prmd", v, 32'h7);
        rd(14'h05, v); chk("ex_ecode", {26'b0, v[21:16]}, 32'hB);
        chk("ex_era", ertn_entry, 32'h1C00_0100);
        ertn = 1'b1; num = 14'h00;
        cyc(); idle_in();
        rd(14'h00, v); chk("ertn_crmd", v, 32'hF);

        // Exception beats a same-cycle CSR write
        idle_in(); ex = 1'b1; ecode = 6'h09; pc = 32'h1C00_0200; vaddr = 32'h1001;
        we = 1'b1; num = 14'h06; wvalue = 32'hDEAD; wmask = 32'hFFFF_FFFF;
        cyc(); idle_in();
        rd(14'h06, v); chk("ale_era", v, 32'h1C00_0200);
        rd(14'h07, v); chk("ale_badv", v, 32'h1001);

        // Hardware interrupt line
        wr(14'h04, 32'h4, 32'hFFFF_FFFF);
        wr(14'h00, 32'h4, 32'h4);
        hw = 8'h01; num = 14'h05;
        cyc();
        rd(14'h05, v); chk("hw_is2_set", {31'b0, v[2]}, 32'h1);
        chk("hw_has_int_set", {31'b0, has_int}, 32'h1);
        hw = 8'h00;
        cyc();
        rd(14'h05, v); chk("hw_is2_clr", {31'b0, v[2]}, 32'h0);
        chk("hw_has_int_clr", {31'b0, has_int}, 32'h0);

`ifdef CSR_TIMER_EN
        // Periodic timer: InitVal 4 -> period 16
        wr(14'h04, 32'h800, 32'hFFFF_FFFF);
        wr(14'h41, 32'h13, 32'hFFFF_FFFF);
        rd(14'h42, v); chk("tval_load", v, 32'h10);
        cnt = 0;
        while (!has_int && cnt < 40) begin cyc(); cnt++; end
        chk("tmr_first_fire", cnt, 16);
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        chk("ticlr_drop", {31'b0, has_int}, 32'h0);
        cnt = 0;
        while (!has_int && cnt < 40) begin cyc(); cnt++; end
        // 16 cycles after the TICLR write cycle
        chk("tmr_period", cnt, 15);
        cnt = 0;
        rd(14'h42, v);
        while (v !== 32'h1 && cnt < 40) begin cyc(); rd(14'h42, v); cnt++; end
        chk("tval_reaches_one", v, 32'h1);
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        rd(14'h05, v); chk("fire_beats_ticlr", {31'b0, v[11]}, 32'h1);
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        wr(14'h41, 32'h1, 32'hFFFF_FFFF);
        num = 14'h42;
        repeat (5) cyc();
        rd(14'h42, v); chk("init0_tval", v, 32'h0);
        rd(14'h05, v); chk("init0_no_fire", {31'b0, v[11]}, 32'h0);
        wr(14'h41, 32'h0, 32'hFFFF_FFFF);
`else
        wr(14'h04, 32'h800, 32'hFFFF_FFFF);
        wr(14'h41, 32'h13, 32'hFFFF_FFFF);
        num = 14'h42;
        repeat (20) cyc();
        rd(14'h41, v); chk("no_tmr_tcfg", v, 32'h0);
        rd(14'h42, v); chk("no_tmr_tval", v, 32'h0);
        chk("no_tmr_has_int", {31'b0, has_int}, 32'h0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            idle_in();
            num    = nums[$urandom_range(0, 17)];
            we     = ($urandom_range(0, 1) == 1);
            wvalue = $urandom;
            wmask  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            if (num == 14'h41) begin
                r = $urandom_range(0, 12);
                wvalue = (r << 2) | {30'b0, r[1:0]};
                wmask  = 32'hFFFF_FFFF;
            end
            ex    = ($urandom_range(0, 19) == 0);
            ertn  = ($urandom_range(0, 19) == 0);
            ecode = ($urandom_range(0, 3) == 0) ? 6'(($urandom)) : ecodes[$urandom_range(0, 3)];
            r     = $urandom; esub = r[8:0];
            pc    = $urandom;
            vaddr = $urandom;
            if ($urandom_range(0, 3) == 0) begin r = $urandom; hw = r[7:0]; end
            if ($urandom_range(0, 7) == 0) ipi = ~ipi;
            reset = ($urandom_range(0, 149) == 0);
            cyc();
        end
        reset = 1'b0;

        // Reset mid-count with a coincident exception and write
        wr(14'h04, 32'h1FFF, 32'hFFFF_FFFF);
        wr(14'h00, 32'h4, 32'h4);
        wr(14'h41, 32'h13, 32'hFFFF_FFFF);
        hw = 8'hFF;
        repeat (3) cyc();
        idle_in(); reset = 1'b1; ex = 1'b1; ecode = 6'h08; pc = 32'h1234_5678;
        we = 1'b1; num = 14'h30; wvalue = 32'hFFFF_FFFF; wmask = 32'hFFFF_FFFF;
        cyc();
        idle_in(); reset = 1'b0; hw = 8'h0; ipi = 1'b0;
        rd(14'h00, v); chk("rst_crmd", v, 32'h8);
        rd(14'h05, v); chk("rst_estat", v, 32'h0);
        rd(14'h42, v); chk("rst_tval", v, 32'h0);
        chk("rst_era", ertn_entry, 32'h0);
        chk("rst_has_int", {31'b0, has_int}, 32'h0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
# csr_unit

Control/status register file at the receiving end of the writeback-stage CSR interface. Holds the privileged LoongArch CSRs and serves CSR reads. Applies masked CSR writes, exception commits and `ertn` returns from WB. Runs the stable timer, samples interrupt lines and hands exception/return entry addresses back to the fetch stage.

## Interface
- No parameters. Widths come from the shared header `macro.vh`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `csr_ctrl` in 80: packed as {csr_re, csr_num[13:0], csr_we, csr_wmask[31:0], csr_wvalue[31:0]}. The producer has already qualified `csr_we` with stage valid.
- `to_csr_in_bus` in `WB2CSR_LEN` (81): packed as {ertn_flush, wb_ex, wb_ecode[5:0], wb_esubcode[8:0], wb_pc[31:0], wb_vaddr[31:0]}. `ertn_flush` and `wb_ex` arrive valid-qualified.
- `hw_int_in` in 8: level hardware interrupt lines.
- `ipi_int_in` in 1: inter-processor interrupt, level.
- `csr_rvalue` out 32: read data for `csr_num`.
- `ex_entry` out 32: current EENTRY value.
- `ertn_entry` out 32: current ERA value.
- `has_int` out 1: an interrupt is pending and enabled.

## Operation
- Implemented CSRs and reset values. Every other field resets to 0.
  - CRMD: {DA[3], IE[2], PLV[1:0]}, resets to 0x8.
  - PRMD: {PIE[2], PPLV[1:0]}.
  - ECFG: LIE[12:0], excluding bit 10.
  - ESTAT: {EsubCode[30:22], Ecode[21:16], IS[12:0]}.
  - ERA, BADV, SAVE0–3 and TID: full 32 bits.
  - EENTRY: VA[31:6].
  - TCFG: {InitVal[31:2], Periodic[1], En[0]}.
  - TVAL: read-only.
  - TICLR: write-only; always reads 0.
- Reads:
  - `csr_rvalue` is combinational from `csr_num` and the current register state.
  - Unmapped numbers read 0. Reserved bits read 0.
  - A read in the same cycle as a write to the same CSR returns the pre-write value.
- Writes:
  - Writable fields update as new = (old & ~wmask) | (wvalue & wmask).
  - Writes to read-only fields are ignored. Only ESTAT.IS[1:0] are software-writable within ESTAT.
- Exception commit (`wb_ex`=1):
  - PRMD.{PPLV,PIE} ← CRMD.{PLV,IE}, then CRMD.PLV←0 and CRMD.IE←0.
  - ESTAT.Ecode ← `wb_ecode` and ESTAT.EsubCode ← `wb_esubcode`.
  - ERA ← `wb_pc`.
  - BADV ← `wb_vaddr` when Ecode is ADE or ALE; otherwise BADV holds.
- Return (`ertn_flush`=1): CRMD.PLV ← PRMD.PPLV and CRMD.IE ← PRMD.PIE.
- Priority when events coincide: `wb_ex` > `ertn_flush` > CSR write. The lower-priority action is fully discarded, including a CSR write to an unrelated CSR.
- Interrupt sources:
  - IS[9:2] ← `hw_int_in` every cycle.
  - IS[12] ← `ipi_int_in` every cycle.
  - IS[11] is set by the timer and cleared by writing TICLR with bit0=1.
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), computed combinationally from registers.
- Timer states: IDLE when En=0 or TVAL=0; COUNT otherwise.
  - A TCFG write with new En=1 loads TVAL ← {InitVal, 2'b00}. An InitVal of 0 loads 0, and the timer stays IDLE with no interrupt.
  - In COUNT, TVAL decrements by 1 each cycle.
  - On the 1→0 step, IS[11] is set. If Periodic=1, TVAL reloads {InitVal, 2'b00} in that same step instead of reaching 0; otherwise TVAL holds 0.
  - A TCFG write with En=0 freezes TVAL.
  - If a timer fire and a TICLR clear land in the same cycle, the fire wins and IS[11] ends at 1.

## Timing
- CSR writes, exception commits and `ertn` updates are visible on `csr_rvalue`, `ex_entry`, `ertn_entry` and `has_int` in the cycle after the event.
- `hw_int_in` and `ipi_int_in` reach `has_int` with 1 cycle of latency.
- Reset asserted in any cycle, including mid-count or mid-exception:
  - All state returns to reset values on the next edge.
  - `csr_rvalue` reads reset values and `has_int`=0 in the following cycle.
- There is no handshake. The block always accepts and never stalls.

## Configuration
- Macro: `CSR_TIMER_EN`.
- With the macro defined: TCFG, TVAL and TICLR are implemented and `csr_timer` is instantiated.
- Without the macro: those CSR numbers read 0, writes to them are ignored, IS[11] is hardwired 0 and no timer logic is generated.

## Structure
- The following live in `macro.vh`:
  - `WB2CSR_LEN`.
  - CSR numbers: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0–3 0x30–0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
  - Field bit positions and the `ECODE_*`/`ESUBCODE_*` constants.
- Sub-module `csr_timer` owns TVAL and the IDLE/COUNT logic. Its outputs are `tval` and a one-cycle `timer_fire` pulse.

## Test plan
- Reset exception state: apply reset → CRMD reads 0x8, ESTAT reads 0, `has_int`=0.
- Masked write: write EENTRY 0x1C008000 with mask 0xFFFFFFFF → `ex_entry`=0x1C008000 next cycle. Then write 0xFFFFFFFF with mask 0x0000003F → `ex_entry` stays 0x1C008000.
- Exception commit and return:
  - With CRMD=0xF, drive `wb_ex`=1, ecode 0xB, pc 0x1C000100 → next cycle CRMD=0x8, PRMD=0x7, ESTAT[21:16]=0xB, `ertn_entry`=0x1C000100.
  - Then drive `ertn_flush`=1 → CRMD=0xF.
- Exception beats CSR write: `wb_ex` (ALE, pc 0x1C000200, vaddr 0x1001) with a same-cycle write of 0xDEAD to ERA → ERA=0x1C000200, BADV=0x1001.
- Periodic timer:
  - Program ECFG=0x800, CRMD.IE=1, TCFG=0x13 → TVAL=0x10, and `has_int` rises 17 cycles after the write.
  - Write TICLR=1 → `has_int` drops next cycle and rises again 16 cycles later.
  - A fire coinciding with a TICLR write leaves IS[11]=1.
- Hardware interrupt: with ECFG=0x4 and IE=1, assert `hw_int_in`=0x01 → IS[2]=1 and `has_int`=1 one cycle later. Deassert → both clear one cycle later.
